// File: rtl/instruction_fetch.sv
// Fetch stage: issues in-order instruction memory requests under a credit limit
// and buffers returned {pc, instr} pairs for the IF/ID register.
module instruction_fetch #(
  parameter logic [63:0] RESET_PC = 64'h0,
  parameter int unsigned DEPTH    = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        redirect,
  input  logic [63:0] redirect_pc,
  output logic        imem_req_valid,
  output logic [63:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  output logic [63:0] PC_out,
  output logic [31:0] Instruction,
  output logic        fetch_valid
);

  localparam int unsigned AW  = $clog2(DEPTH);
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam logic [31:0] NOP = 32'h0000_0013;

  typedef logic [CW-1:0] cnt_t;
  typedef logic [AW-1:0] ptr_t;

  logic [63:0] fetch_pc;
  cnt_t        inflight;
  cnt_t        drop_cnt;
  cnt_t        occ;

  logic [63:0] pcq [DEPTH];
  ptr_t        pcq_wr;
  ptr_t        pcq_rd;

  logic [63:0] fifo_pc    [DEPTH];
  logic [31:0] fifo_instr [DEPTH];
  ptr_t        fifo_wr;
  ptr_t        fifo_rd;

  logic [CW+1:0] credit_used;
  logic          accept;
  logic          rsp_keep;
  logic          pop;

  // Stale responses still hold credit until dropped, so the buffer can never overflow.
  assign credit_used    = (CW+2)'(inflight) + (CW+2)'(drop_cnt) + (CW+2)'(occ);
  assign imem_req_valid = reset && (credit_used < (CW+2)'(DEPTH));
  assign imem_req_addr  = fetch_pc;
  assign accept         = imem_req_valid && imem_req_ready;
  assign rsp_keep       = imem_rsp_valid && (drop_cnt == '0);

  assign fetch_valid = (occ != '0);
  assign pop         = fetch_valid && !stall;
  assign PC_out      = fetch_valid ? fifo_pc[fifo_rd]    : 64'h0;
  assign Instruction = fetch_valid ? fifo_instr[fifo_rd] : NOP;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fetch_pc <= RESET_PC;
      inflight <= '0;
      drop_cnt <= '0;
      occ      <= '0;
      pcq_wr   <= '0;
      pcq_rd   <= '0;
      fifo_wr  <= '0;
      fifo_rd  <= '0;
    end else if (redirect) begin
      // Everything outstanding, including this cycle's accept, becomes stale;
      // a response landing now is consumed as one of them.
      fetch_pc <= {redirect_pc[63:2], 2'b00};
      drop_cnt <= drop_cnt + inflight + cnt_t'(accept) - cnt_t'(imem_rsp_valid);
      inflight <= '0;
      occ      <= '0;
      pcq_wr   <= '0;
      pcq_rd   <= '0;
      fifo_wr  <= '0;
      fifo_rd  <= '0;
    end else begin
      if (accept) begin
        fetch_pc <= fetch_pc + 64'd4;
        pcq_wr   <= pcq_wr + ptr_t'(1);
      end
      if (imem_rsp_valid && (drop_cnt != '0))
        drop_cnt <= drop_cnt - cnt_t'(1);
      if (rsp_keep) begin
        pcq_rd  <= pcq_rd + ptr_t'(1);
        fifo_wr <= fifo_wr + ptr_t'(1);
      end
      if (pop)
        fifo_rd <= fifo_rd + ptr_t'(1);

      if (accept && !rsp_keep)
        inflight <= inflight + cnt_t'(1);
      else if (!accept && rsp_keep)
        inflight <= inflight - cnt_t'(1);

      if (rsp_keep && !pop)
        occ <= occ + cnt_t'(1);
      else if (!rsp_keep && pop)
        occ <= occ - cnt_t'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (accept && !redirect)
      pcq[pcq_wr] <= fetch_pc;
    if (rsp_keep && !redirect) begin
      fifo_pc[fifo_wr]    <= pcq[pcq_rd];
      fifo_instr[fifo_wr] <= imem_rsp_data;
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: fill, stall, redirects with stale
// responses, random ready with address wrap, and async reset mid-stream.
module tb_instruction_fetch;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic        redirect;
  logic [63:0] redirect_pc;
  logic        imem_req_valid;
  logic [63:0] imem_req_addr;
  logic        mem_ready = 1'b0;
  logic        rsp_valid = 1'b0;
  logic [31:0] rsp_data  = 32'h0;
  logic [63:0] pc_out;
  logic [31:0] instruction;
  logic        fetch_valid;

  int n_assert = 0;
  int n_fail   = 0;

  logic ready_val  = 1'b1;
  logic ready_rand = 1'b0;
  int   mem_lat    = 1;

  instruction_fetch #(.RESET_PC(64'h1000), .DEPTH(4)) dut (
    .clk            (clk),
    .reset          (reset),
    .stall          (stall),
    .redirect       (redirect),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_addr  (imem_req_addr),
    .imem_req_ready (mem_ready),
    .imem_rsp_valid (rsp_valid),
    .imem_rsp_data  (rsp_data),
    .PC_out         (pc_out),
    .Instruction    (instruction),
    .fetch_valid    (fetch_valid)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return a[31:0] ^ 32'h5A5A_0000;
  endfunction

  // Memory model: fixed latency, in order, reset together with the DUT.
  logic [63:0] q_addr [$];
  int          q_due  [$];
  int          cyc = 0;
  int          due;

  always begin
    @(negedge clk);
    #1;
    cyc++;
    if (!reset) begin
      q_addr.delete();
      q_due.delete();
      rsp_valid = 1'b0;
      mem_ready = 1'b0;
    end else begin
      rsp_valid = 1'b0;
      if (q_due.size() > 0 && q_due[0] <= cyc) begin
        rsp_valid = 1'b1;
        rsp_data  = mem_word(q_addr[0]);
        void'(q_addr.pop_front());
        void'(q_due.pop_front());
      end
      mem_ready = ready_rand ? 1'($urandom_range(0, 1)) : ready_val;
      if (imem_req_valid && mem_ready) begin
        due = cyc + mem_lat;
        if (q_due.size() > 0 && due <= q_due[$]) due = q_due[$] + 1;
        q_addr.push_back(imem_req_addr);
        q_due.push_back(due);
      end
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic chk_head(input string tag, input logic [63:0] pc);
    chk({tag, "_valid"}, 64'(fetch_valid), 64'd1);
    chk({tag, "_pc"}, pc_out, pc);
    chk({tag, "_instr"}, 64'(instruction), 64'(mem_word(pc)));
  endtask

  task automatic chk_empty(input string tag);
    chk({tag, "_valid"}, 64'(fetch_valid), 64'd0);
    chk({tag, "_pc"}, pc_out, 64'h0);
    chk({tag, "_instr"}, 64'(instruction), 64'h13);
  endtask

  task automatic chk_req(input string tag, input logic v, input logic [63:0] a);
    chk({tag, "_req_valid"}, 64'(imem_req_valid), 64'(v));
    if (v) chk({tag, "_req_addr"}, imem_req_addr, a);
  endtask

  logic [63:0] exp_req;
  logic [63:0] exp_pc;
  logic        prev_v;
  int          delivered;

  initial begin
    reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 64'h0;
    repeat (2) @(negedge clk);
    chk_empty("reset");
    chk_req("reset", 1'b0, 64'h0);

    // Fill at latency 1
    reset = 1'b1;
    #2 chk_req("first_req", 1'b1, 64'h1000);
    @(negedge clk);
    chk_empty("fill_c1");
    chk_req("fill_c1", 1'b1, 64'h1004);
    for (int k = 2; k <= 5; k++) begin
      @(negedge clk);
      chk_head("stream", 64'h1000 + 64'(4 * (k - 2)));
    end

    // Stall five cycles: head frozen, credit exhausted after three more issues
    stall = 1'b1;
    @(negedge clk); chk_head("stall_c6", 64'h100C); chk_req("stall_c6", 1'b1, 64'h1018);
    @(negedge clk); chk_head("stall_c7", 64'h100C); chk_req("stall_c7", 1'b0, 64'h0);
    @(negedge clk); chk_head("stall_c8", 64'h100C); chk_req("stall_c8", 1'b0, 64'h0);
    @(negedge clk); chk_head("stall_c9", 64'h100C); chk_req("stall_c9", 1'b0, 64'h0);
    @(negedge clk); chk_head("stall_c10", 64'h100C); chk_req("stall_c10", 1'b0, 64'h0);
    stall = 1'b0;
    for (int k = 11; k <= 16; k++) begin
      @(negedge clk);
      chk_head("after_stall", 64'h1010 + 64'(4 * (k - 11)));
    end

    // Async reset between clock edges
    #3 reset = 1'b0;
    #1 chk_empty("async_rst");
    chk_req("async_rst", 1'b0, 64'h0);
    mem_lat = 3;
    @(negedge clk);
    @(negedge clk);

    // Redirect with two requests in flight, latency 3
    reset = 1'b1;
    #2 chk_req("restart", 1'b1, 64'h1000);
    @(negedge clk);
    chk_req("lat3_c1", 1'b1, 64'h1004);
    @(negedge clk);
    chk_req("lat3_c2", 1'b1, 64'h1008);
    ready_val = 1'b0; redirect = 1'b1; redirect_pc = 64'h2002;
    @(negedge clk);
    redirect = 1'b0; ready_val = 1'b1;
    chk_empty("redir1_c3");
    chk_req("redir1_c3", 1'b1, 64'h2000);
    @(negedge clk); chk_empty("redir1_c4");
    @(negedge clk); chk_empty("redir1_c5");
    @(negedge clk); chk_empty("redir1_c6");
    for (int k = 7; k <= 10; k++) begin
      @(negedge clk);
      chk_head("redir1_stream", 64'h2000 + 64'(4 * (k - 7)));
    end

    // Redirect coinciding with a response and an accept, latency 1
    reset = 1'b0;
    mem_lat = 1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    #2 chk_req("restart2", 1'b1, 64'h1000);
    @(negedge clk); chk_empty("r2_c1");
    @(negedge clk); chk_head("r2_c2", 64'h1000);
    @(negedge clk); chk_head("r2_c3", 64'h1004);
    redirect = 1'b1; redirect_pc = 64'h3000;
    @(negedge clk);
    redirect = 1'b0;
    chk_empty("redir2_c4");
    chk_req("redir2_c4", 1'b1, 64'h3000);
    @(negedge clk); chk_empty("redir2_c5");
    @(negedge clk); chk_head("redir2_c6", 64'h3000);
    @(negedge clk); chk_head("redir2_c7", 64'h3004);
    @(negedge clk); chk_head("redir2_c8", 64'h3008);
    redirect = 1'b1; redirect_pc = 64'hFFFF_FFFF_FFFF_FFF2;

    // Random ready across the 64-bit wrap
    @(negedge clk);
    redirect = 1'b0; ready_rand = 1'b1;
    chk_empty("wrap_start");
    chk_req("wrap_start", 1'b1, 64'hFFFF_FFFF_FFFF_FFF0);
    exp_req   = 64'hFFFF_FFFF_FFFF_FFF0;
    exp_pc    = 64'hFFFF_FFFF_FFFF_FFF0;
    prev_v    = 1'b1;
    delivered = 0;
    for (int c = 0; c < 300 && delivered < 10; c++) begin
      @(negedge clk);
      if (prev_v && mem_ready) exp_req = exp_req + 64'd4;
      if (imem_req_valid) chk("rand_req_addr", imem_req_addr, exp_req);
      prev_v = imem_req_valid;
      if (fetch_valid) begin
        chk("rand_pc", pc_out, exp_pc);
        chk("rand_instr", 64'(instruction), 64'(mem_word(exp_pc)));
        exp_pc = exp_pc + 64'd4;
        delivered++;
      end
    end
    chk("rand_delivered", 64'(delivered), 64'd10);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
